// File: rtl/conv1d_seq_ctrl.sv
// conv1d_seq_ctrl: address/accumulator sequencer for the conv1d MAC datapath.
// Walks o (output index) and t (tap index), drives the accumulator controls,
// and hands each finished output downstream over a valid/ready handshake.
module conv1d_seq_ctrl #(
  parameter int unsigned N_TAPS    = 3,
  parameter int unsigned N_SAMPLES = 16,
  parameter int unsigned ADDR_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  parameter int unsigned TAP_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] x_addr,
  output logic [TAP_W-1:0]  w_addr,
  output logic              acc_sel,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int unsigned N_OUT = N_SAMPLES - N_TAPS + 1;
  localparam logic [TAP_W-1:0]  T_LAST = TAP_W'(N_TAPS - 1);
  localparam logic [ADDR_W-1:0] O_LAST = ADDR_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] o, o_d;
  logic [TAP_W-1:0]  t, t_d;

  logic              busy_d, done_d, acc_sel_d, acc_en_d, out_valid_d;
  logic [ADDR_W-1:0] x_addr_d, out_addr_d;
  logic [TAP_W-1:0]  w_addr_d;

  // Next-state/counter logic; outputs are decoded from the next state so that
  // every port comes straight from a flop.
  always_comb begin
    state_d     = state;
    o_d         = o;
    t_d         = t;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    acc_sel_d   = 1'b0;
    acc_en_d    = 1'b0;
    out_valid_d = 1'b0;
    x_addr_d    = '0;
    w_addr_d    = '0;
    out_addr_d  = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          o_d     = '0;
          t_d     = '0;
        end
      end
      S_MAC: begin
        if (t == T_LAST) state_d = S_WRITE;
        else             t_d     = t + TAP_W'(1);
      end
      S_WRITE: begin
        if (out_ready) begin
          if (o == O_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MAC;
            o_d     = o + ADDR_W'(1);
            t_d     = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    acc_en_d    = (state_d == S_MAC);
    acc_sel_d   = (state_d == S_MAC) && (t_d != '0);
    out_valid_d = (state_d == S_WRITE);
    if (state_d == S_MAC || state_d == S_WRITE) begin
      x_addr_d = o_d + ADDR_W'(t_d);
      w_addr_d = t_d;
    end
    if (state_d == S_WRITE) out_addr_d = o_d;
  end

  // State, counters and registered outputs; synchronous reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      o         <= '0;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_sel   <= 1'b0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      out_addr  <= '0;
    end else begin
      state     <= state_d;
      o         <= o_d;
      t         <= t_d;
      busy      <= busy_d;
      done      <= done_d;
      acc_sel   <= acc_sel_d;
      acc_en    <= acc_en_d;
      out_valid <= out_valid_d;
      x_addr    <= x_addr_d;
      w_addr    <= w_addr_d;
      out_addr  <= out_addr_d;
    end
  end

endmodule

// File: doc/conv1d_seq_ctrl.md
# conv1d_seq_ctrl

Sequencer for the conv1d core datapath. It walks the sample and weight address spaces, and drives the 2:1 accumulator-input mux select (restart vs. feedback) and the accumulator enable. It also hands each finished output to the downstream buffer through a valid/ready handshake. It sits between the top-level start/done control and the MAC datapath (memories, multiplier, accumulator mux, accumulator register).

## Interface

Parameters:
- N_TAPS, default 3: kernel length; legal range 1..N_SAMPLES.
- N_SAMPLES, default 16: input vector length.
- ADDR_W, default $clog2(N_SAMPLES) (minimum 1): sample/output address width.
- TAP_W, default $clog2(N_TAPS) (minimum 1): weight address width.

Ports:
- clk, in, 1: single clock; all state is updated on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a convolution pass; sampled only in IDLE.
- busy, out, 1: high from the first MAC cycle through the DONE cycle inclusive.
- done, out, 1: one-cycle pulse marking the end of a pass.
- x_addr, out, ADDR_W: sample memory read address.
- w_addr, out, TAP_W: weight memory read address.
- acc_sel, out, 1: accumulator mux select; 0 = restart (load product only), 1 = feedback (add product to accumulator).
- acc_en, out, 1: accumulator register load enable.
- out_valid, out, 1: accumulator holds a finished output.
- out_ready, in, 1: downstream accepts the output.
- out_addr, out, ADDR_W: index of the output currently presented.

## Operation

- Output count N_OUT = N_SAMPLES - N_TAPS + 1 (valid convolution, no padding).
- Internal counters:
  - o: output index, 0..N_OUT-1.
  - t: tap index, 0..N_TAPS-1.
- IDLE:
  - All outputs 0.
  - start=1 → MAC with o=0, t=0.
  - start=0 → stay in IDLE.
- MAC:
  - x_addr = o+t, w_addr = t, acc_en = 1.
  - acc_sel = 0 when t==0, otherwise 1.
  - t==N_TAPS-1 → WRITE; otherwise t increments.
  - With N_TAPS=1, every MAC cycle has acc_sel=0.
- WRITE:
  - out_valid = 1, out_addr = o, acc_en = 0.
  - x_addr and w_addr hold their last values.
  - Stay in WRITE while out_ready=0; out_valid, out_addr and the accumulator stay stable.
  - On out_valid && out_ready:
    - if o==N_OUT-1 → DONE;
    - otherwise o increments, t=0, go to MAC.
- DONE:
  - done = 1 for exactly this cycle, busy = 1.
  - Next state is IDLE unconditionally; start is ignored in this cycle.
- Start handling:
  - start asserted outside IDLE is ignored; there is no queuing.
  - start held high continuously relaunches a pass on every IDLE visit.
- Address arithmetic:
  - o+t is at most N_SAMPLES-1 and always fits in ADDR_W without wrap.
  - Counters do not wrap; they are reloaded only on the transitions above.
- Reset:
  - rst=1 in any state (including mid-MAC or mid-WRITE) → IDLE on that edge.
  - o and t clear to 0.
  - Reset has priority over start and out_ready.
- Reset values: busy, done, acc_en, acc_sel, out_valid = 0; x_addr, w_addr, out_addr = 0.

## Timing

- All outputs are registered or decoded from registered state. There is no combinational path from out_ready or start to any output.
- Memory reads are combinational. The accumulator registers on the same edge at which the address is presented with acc_en=1.
- Cycle numbering: start sampled at edge 0 → first MAC cycle is cycle 1.
- Per output: N_TAPS MAC cycles + 1 WRITE cycle (plus any stall cycles).
- Zero-stall pass (out_ready=1 throughout):
  - done is high in cycle N_OUT*(N_TAPS+1)+1.
  - The block is back in IDLE the cycle after done.
  - Earliest restart: start sampled in the first IDLE cycle → MAC in the next cycle.
- Each out_ready=0 cycle in WRITE adds exactly one cycle to the total.

## Test plan

- Reset check: assert rst for 2 cycles → all outputs 0, block in IDLE; start=0 thereafter → outputs stay 0.
- Nominal pass, N_TAPS=3, N_SAMPLES=8, out_ready=1:
  - pulse start at cycle 0;
  - x_addr sequence 0,1,2 | 1,2,3 | … | 5,6,7; w_addr 0,1,2 repeating;
  - acc_sel 0,1,1 per group;
  - out_valid in cycles 4,8,…,24 with out_addr 0..5;
  - done only in cycle 25; busy high in cycles 1–25.
- Backpressure: same config, out_ready=0 for 3 cycles at the first WRITE → out_valid held 4 cycles with out_addr=0 and acc_en=0; done moves to cycle 28.
- Reset mid-operation: rst at cycle 6 (inside MAC of o=1) → IDLE and all outputs 0 at cycle 7; a fresh start then restarts at o=0, t=0 with the nominal sequence.
- Edge configurations:
  - N_TAPS=1, N_SAMPLES=4: acc_sel always 0; 4 outputs; done at cycle 9.
  - N_TAPS=N_SAMPLES=4: single output; x_addr 0..3; done at cycle 6.
- Spurious start: start held high for an entire pass → no restart until after DONE; second pass begins exactly 1 IDLE cycle after done.
